// File: rtl/note_arbiter.sv
// Shares one buzzer between a live and an auto note source: grants one note at a
// time, plays it for a length-derived number of beat ticks, then inserts a silent gap.
module note_arbiter #(
    parameter int OCTAVE_BITS = 3,
    parameter int NOTE_BITS   = 3,
    parameter int LENGTH_BITS = 3,
    parameter int TICK_DIV    = 50000,
    parameter int GAP_TICKS   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   preempt_en,
    input  logic                   live_valid,
    output logic                   live_ready,
    input  logic [OCTAVE_BITS-1:0] live_octave,
    input  logic [NOTE_BITS-1:0]   live_note,
    input  logic [LENGTH_BITS-1:0] live_length,
    input  logic                   auto_valid,
    output logic                   auto_ready,
    input  logic [OCTAVE_BITS-1:0] auto_octave,
    input  logic [NOTE_BITS-1:0]   auto_note,
    input  logic [LENGTH_BITS-1:0] auto_length,
    output logic                   out_active,
    output logic [OCTAVE_BITS-1:0] out_octave,
    output logic [NOTE_BITS-1:0]   out_note,
    output logic                   out_src,
    output logic                   busy,
    output logic                   note_done,
    output logic                   note_abort,
    output logic [1:0]             dbg_state
);

    // Handshake: a note transfers on a clock edge where valid && ready; ready is
    // only ever high in IDLE, and fields must be held stable while valid && !ready.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]        TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [15:0]          GAP_LOAD  = 16'(GAP_TICKS);
    localparam logic [NOTE_BITS-1:0] REST      = NOTE_BITS'(7);

    state_t          state;
    logic [TW-1:0]   tick_cnt;
    logic [7:0]      remaining;
    logic [15:0]     gap_left;
    logic            tick_wrap;
    logic            preempt;

    // Length codes 0..6 double the tick count; the top code saturates at 128.
    function automatic logic [7:0] duration(input logic [LENGTH_BITS-1:0] len);
        if (32'(len) >= 7) return 8'd128;
        else return 8'd1 << len;
    endfunction

    assign tick_wrap  = (tick_cnt == TICK_LAST);
    assign live_ready = ~rst & (state == IDLE) & live_valid;
    assign auto_ready = ~rst & (state == IDLE) & auto_valid & ~live_valid;
    assign preempt    = ~rst & (state == PLAY) & out_src & preempt_en & live_valid;
    assign note_abort = preempt;
    assign note_done  = ~rst & (state == PLAY) & ~preempt & tick_wrap & (remaining == 8'd1);
    assign busy       = (state != IDLE);
    assign dbg_state  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            remaining  <= '0;
            gap_left   <= '0;
            out_active <= 1'b0;
            out_octave <= '0;
            out_note   <= '0;
            out_src    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (live_valid) begin
                        out_octave <= live_octave;
                        out_note   <= live_note;
                        out_src    <= 1'b0;
                        out_active <= (live_note != REST);
                        remaining  <= duration(live_length);
                        tick_cnt   <= '0;
                        state      <= PLAY;
                    end else if (auto_valid) begin
                        out_octave <= auto_octave;
                        out_note   <= auto_note;
                        out_src    <= 1'b1;
                        out_active <= (auto_note != REST);
                        remaining  <= duration(auto_length);
                        tick_cnt   <= '0;
                        state      <= PLAY;
                    end
                end
                PLAY: begin
                    if (preempt) begin
                        out_active <= 1'b0;
                        tick_cnt   <= '0;
                        state      <= IDLE;
                    end else if (tick_wrap) begin
                        tick_cnt  <= '0;
                        remaining <= remaining - 8'd1;
                        if (remaining == 8'd1) begin
                            out_active <= 1'b0;
                            if (GAP_TICKS > 0) begin
                                gap_left <= GAP_LOAD;
                                state    <= GAP;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                GAP: begin
                    if (tick_wrap) begin
                        tick_cnt <= '0;
                        gap_left <= gap_left - 16'd1;
                        if (gap_left == 16'd1) state <= IDLE;
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_arbiter.sv
// Directed bench for note_arbiter with TICK_DIV=4, GAP_TICKS=1; completed notes
// are scored against an expected queue of {src, octave, note}.
module tb_note_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       preempt_en = 1'b0;
    logic       live_valid = 1'b0, auto_valid = 1'b0;
    logic       live_ready, auto_ready;
    logic [2:0] live_octave = '0, live_note = '0, live_length = '0;
    logic [2:0] auto_octave = '0, auto_note = '0, auto_length = '0;
    logic       out_active, out_src, busy, note_done, note_abort;
    logic [2:0] out_octave, out_note;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    logic [6:0] exp_q[$];

    note_arbiter #(
        .OCTAVE_BITS(3), .NOTE_BITS(3), .LENGTH_BITS(3), .TICK_DIV(4), .GAP_TICKS(1)
    ) dut (
        .clk(clk), .rst(rst), .preempt_en(preempt_en),
        .live_valid(live_valid), .live_ready(live_ready),
        .live_octave(live_octave), .live_note(live_note), .live_length(live_length),
        .auto_valid(auto_valid), .auto_ready(auto_ready),
        .auto_octave(auto_octave), .auto_note(auto_note), .auto_length(auto_length),
        .out_active(out_active), .out_octave(out_octave), .out_note(out_note),
        .out_src(out_src), .busy(busy), .note_done(note_done), .note_abort(note_abort),
        .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // scoreboard: every normally completed note must match the next expected grant
    always @(negedge clk) begin
        if (note_done) begin
            if (exp_q.size() == 0) check("sb_unexpected_done", 1, 0);
            else check("sb_note", {out_src, out_octave, out_note}, exp_q.pop_front());
        end
    end

    // driver: offer a live note from IDLE; returns just after the handshake edge
    task automatic offer_live(input logic [2:0] oct, input logic [2:0] nt,
                              input logic [2:0] len, input bit scored);
        @(posedge clk); #1;
        live_octave = oct; live_note = nt; live_length = len; live_valid = 1'b1;
        @(negedge clk);
        check("live_ready_offer", live_ready, 1);
        @(posedge clk); #1;
        live_valid = 1'b0;
        if (scored) exp_q.push_back({1'b0, oct, nt});
    endtask

    task automatic offer_auto(input logic [2:0] oct, input logic [2:0] nt,
                              input logic [2:0] len, input bit scored);
        @(posedge clk); #1;
        auto_octave = oct; auto_note = nt; auto_length = len; auto_valid = 1'b1;
        @(negedge clk);
        check("auto_ready_offer", auto_ready, 1);
        @(posedge clk); #1;
        auto_valid = 1'b0;
        if (scored) exp_q.push_back({1'b1, oct, nt});
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (busy && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", busy, 0);
    endtask

    initial begin
        int cnt_ready, cnt_abort, cnt_done;

        // reset with both requesters asserting
        live_valid = 1'b1; auto_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_live_ready", live_ready, 0);
            check("rst_auto_ready", auto_ready, 0);
        end
        check("rst_outputs", {out_active, out_octave, out_note, out_src, busy, note_done, note_abort}, 0);
        check("rst_state", dbg_state, 0);
        @(posedge clk); #1;
        rst = 1'b0; live_valid = 1'b0; auto_valid = 1'b0;

        // basic live note: length 1 -> 8 play cycles, 4 gap cycles
        offer_live(3'd4, 3'd2, 3'd1, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("t2_active", out_active, 1);
            check("t2_fields", {out_src, out_octave, out_note}, {1'b0, 3'd4, 3'd2});
            check("t2_done", note_done, (i == 8));
        end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("t2_gap_active", out_active, 0);
            check("t2_gap_busy", busy, 1);
        end
        @(negedge clk);
        check("t2_idle_busy", busy, 0);
        check("t2_hold_note", out_note, 2);

        // simultaneous valids: live first, auto waits
        @(posedge clk); #1;
        live_octave = 3'd1; live_note = 3'd3; live_length = 3'd0; live_valid = 1'b1;
        auto_octave = 3'd5; auto_note = 3'd4; auto_length = 3'd0; auto_valid = 1'b1;
        @(negedge clk);
        check("t3_live_ready", live_ready, 1);
        check("t3_auto_ready", auto_ready, 0);
        @(posedge clk); #1;
        live_valid = 1'b0;
        exp_q.push_back({1'b0, 3'd1, 3'd3});
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("t3_auto_blocked", auto_ready, 0);
            if (i <= 4) check("t3_live_src", {out_src, out_note, out_active}, {1'b0, 3'd3, 1'b1});
            else check("t3_gap_active", out_active, 0);
        end
        @(negedge clk);
        check("t3_auto_ready_idle", auto_ready, 1);
        @(posedge clk); #1;
        auto_valid = 1'b0;
        exp_q.push_back({1'b1, 3'd5, 3'd4});
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("t3_auto_play", {out_src, out_octave, out_note, out_active}, {1'b1, 3'd5, 3'd4, 1'b1});
        end
        wait_idle(20);

        // pre-emption enabled: auto length 6, live arrives in PLAY cycle 20
        preempt_en = 1'b1;
        offer_auto(3'd2, 3'd5, 3'd6, 1'b0);
        repeat (19) @(negedge clk);
        check("t4a_still_auto", {out_src, out_active}, 2'b11);
        @(posedge clk); #1;
        live_octave = 3'd6; live_note = 3'd1; live_length = 3'd0; live_valid = 1'b1;
        @(negedge clk);
        check("t4a_abort", note_abort, 1);
        check("t4a_no_done", note_done, 0);
        check("t4a_no_ready", live_ready, 0);
        @(negedge clk);
        check("t4a_idle", {busy, out_active, note_abort}, 0);
        check("t4a_live_ready", live_ready, 1);
        @(posedge clk); #1;
        live_valid = 1'b0;
        exp_q.push_back({1'b0, 3'd6, 3'd1});
        @(negedge clk);
        check("t4a_live_play", {out_src, out_octave, out_note, out_active}, {1'b0, 3'd6, 3'd1, 1'b1});
        wait_idle(20);

        // pre-emption disabled: live waits for auto note and gap
        preempt_en = 1'b0;
        offer_auto(3'd3, 3'd6, 3'd6, 1'b1);
        repeat (19) @(negedge clk);
        @(posedge clk); #1;
        live_octave = 3'd7; live_note = 3'd0; live_length = 3'd0; live_valid = 1'b1;
        cnt_ready = 0; cnt_abort = 0; cnt_done = 0;
        for (int i = 20; i <= 260; i++) begin
            @(negedge clk);
            cnt_ready += int'(live_ready);
            cnt_abort += int'(note_abort);
            if (note_done) begin
                cnt_done++;
                check("t4b_done_cycle", i, 256);
            end
        end
        check("t4b_ready_while_busy", cnt_ready, 0);
        check("t4b_abort_count", cnt_abort, 0);
        check("t4b_done_count", cnt_done, 1);
        @(negedge clk);
        check("t4b_idle_ready", {busy, live_ready}, 2'b01);
        @(posedge clk); #1;
        live_valid = 1'b0;
        exp_q.push_back({1'b0, 3'd7, 3'd0});
        wait_idle(20);

        // rest note: silent for 16 cycles but still timed
        offer_live(3'd1, 3'd7, 3'd2, 1'b1);
        cnt_done = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            check("t5_silent", {out_active, busy, out_note}, {1'b0, 1'b1, 3'd7});
            if (note_done) check("t5_done_cycle", i, 16);
            cnt_done += int'(note_done);
        end
        check("t5_done_count", cnt_done, 1);
        wait_idle(20);

        // reset in PLAY cycle 5
        offer_live(3'd5, 3'd5, 3'd2, 1'b0);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("t6_no_pulse", {note_done, note_abort, live_ready}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_reset_outputs", {out_active, out_octave, out_note, out_src, busy, note_done, note_abort}, 0);
        check("t6_state", dbg_state, 0);
        repeat (3) @(negedge clk);
        check("t6_stays_idle", busy, 0);

        check("sb_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_arbiter.md
# note_arbiter

Playback controller sitting between the note sources and the tone generator. It shares the single buzzer between a live requester (keyboard hit path) and an auto requester (song playback), grants one note at a time over a valid/ready handshake, holds it for a length-derived duration measured in beat ticks, then inserts an articulation gap. Live input has priority and may optionally pre-empt an auto note in progress.

## Interface
- OCTAVE_BITS, 3, octave field width
- NOTE_BITS, 3, note field width; code 7 = rest
- LENGTH_BITS, 3, length code width
- TICK_DIV, 50000, clk cycles per beat tick (≥1)
- GAP_TICKS, 1, silent ticks after each note (0 allowed)

- clk  in  1  system clock; one clock domain
- rst  in  1  synchronous reset, active-high
- preempt_en  in  1  allow live request to abort an auto note
- live_valid  in  1  live note offered
- live_ready  out  1  live note accepted this cycle
- live_octave/live_note/live_length  in  OCTAVE_BITS/NOTE_BITS/LENGTH_BITS  live note fields
- auto_valid  in  1  auto note offered
- auto_ready  out  1  auto note accepted this cycle
- auto_octave/auto_note/auto_length  in  same widths  auto note fields
- out_active  out  1  tone generator enable
- out_octave  out  OCTAVE_BITS  latched octave
- out_note  out  NOTE_BITS  latched note
- out_src  out  1  0 = live, 1 = auto
- busy  out  1  state ≠ IDLE
- note_done  out  1  one-cycle pulse at normal end of PLAY
- note_abort  out  1  one-cycle pulse when auto note is pre-empted

## Operation
- States: IDLE, PLAY, GAP.
- IDLE: live_ready = live_valid; auto_ready = auto_valid & ~live_valid (combinational, fixed live priority). On a handshake, latch octave/note/src, load remaining = duration(length), clear tick divider, go PLAY.
- duration(length): length 0..6 → 1<<length ticks (1..64); length 7 → 128 ticks. Remaining counter 8 bits.
- PLAY: out_active = 1 unless out_note == 7 (rest: out_active 0, duration still counted). Tick divider counts 0..TICK_DIV-1; on wrap remaining decrements. When the decrement reaches 0: note_done pulse, go GAP (GAP_TICKS>0) or IDLE (GAP_TICKS=0).
- Pre-emption: in PLAY with out_src=1, preempt_en=1 and live_valid=1 → note_abort pulse, no note_done, out_active 0, go IDLE; live is granted in that IDLE cycle. Live notes are never pre-empted. preempt_en=0 → live waits.
- GAP: out_active 0, counts GAP_TICKS ticks, then IDLE. Readies are 0 outside IDLE.
- out_octave/out_note/out_src hold last latched values through GAP and IDLE.
- Requesters must hold fields stable while valid is high and ready low.

## Timing
- Reset: state IDLE, out_active/out_octave/out_note/out_src/busy/note_done/note_abort = 0, counters 0; readies 0 while rst high.
- Handshake at edge N → out_active (and busy) high from cycle N+1.
- PLAY lasts exactly duration·TICK_DIV cycles; note_done asserted in the last PLAY cycle.
- GAP lasts GAP_TICKS·TICK_DIV cycles; then ≥1 IDLE cycle. Back-to-back note period = (duration+GAP_TICKS)·TICK_DIV + 1 cycles.
- Abort: note_abort and exit in the cycle live_valid is first seen in PLAY; IDLE next cycle; live handshake there; new note audible one cycle later.
- rst mid-operation: next cycle IDLE with reset values; no note_done/note_abort pulse.
- Simultaneous live and auto valid in IDLE: live only; auto stays pending.

## Test plan
- Reset: hold rst 3 cycles with both valids high → all outputs 0, no ready.
- TICK_DIV=4, GAP_TICKS=1, live octave 4 note 2 length 1 → out_active high 8 cycles, note_done in 8th, 4 gap cycles, busy low after 12.
- Both valid in IDLE, lengths 0 → live granted first (out_src 0, 4 cycles), auto_ready low until IDLE returns, then auto played with out_src 1.
- Auto length 6 (256 cycles), live_valid at PLAY cycle 20: preempt_en=1 → note_abort, live granted next cycle; preempt_en=0 → live waits until auto note + gap complete.
- Live note 7 length 2 → out_active 0 for 16 cycles, out_note 7, note_done pulses.
- Assert rst at PLAY cycle 5 → next cycle IDLE, outputs 0, no done/abort pulse.
